// File: rtl/stepper_pkg.sv
// Shared types and widths for the stepper pulse generator.
package stepper_pkg;
  localparam int STEP_CNT_W = 31;
  localparam int POS_W      = 32;
  localparam int PERIOD_W   = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW
  } state_t;
endpackage

// File: rtl/stepper_sync2.sv
// Two-flop synchronizer for an asynchronous level input.
module stepper_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/stepper_pulse_gen.sv
// STEP/DIR pulse generator with setup delay, period clamp, abort and position tracking.
// Define STEPPER_ENDSTOP_ABORT_EN to let the endstop in the travel direction abort a move.
module stepper_pulse_gen
  import stepper_pkg::*;
#(
  parameter int unsigned PULSE_WIDTH = 4,
  parameter int unsigned DIR_SETUP   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [STEP_CNT_W-1:0] cmd_steps,
  input  logic                  cmd_dir,
  input  logic [PERIOD_W-1:0]   cmd_period,
  input  logic                  abort,
  input  logic                  pos_clear,
  input  logic                  endstop_min,
  input  logic                  endstop_max,
  output logic                  step,
  output logic                  dir,
  output logic                  busy,
  output logic [STEP_CNT_W-1:0] steps_left,
  output logic [POS_W-1:0]      position,
  output logic                  done,
  output logic                  aborted
);
  localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(2 * PULSE_WIDTH);
  localparam logic [31:0]         PW_LAST    = 32'(PULSE_WIDTH - 1);
  localparam logic [31:0]         SETUP_LAST = 32'(DIR_SETUP - 1);

  state_t                state, next_state;
  logic [31:0]           cnt;
  logic [PERIOD_W-1:0]   low_cycles;
  logic [PERIOD_W-1:0]   eff_period;
  logic                  abort_pend;
  logic                  es_min_s, es_max_s;
  logic                  abort_eff, start_blocked;
  logic                  accept, rise, take_step, finish, finish_abort, pend_set;

  stepper_sync2 u_sync_min (.clk(clk), .reset(reset), .d(endstop_min), .q(es_min_s));
  stepper_sync2 u_sync_max (.clk(clk), .reset(reset), .d(endstop_max), .q(es_max_s));

`ifdef STEPPER_ENDSTOP_ABORT_EN
  assign abort_eff     = abort | (dir ? es_max_s : es_min_s);
  assign start_blocked = cmd_dir ? es_max_s : es_min_s;
`else
  logic unused_endstops;
  assign unused_endstops = es_min_s ^ es_max_s;
  assign abort_eff       = abort;
  assign start_blocked   = 1'b0;
`endif

  assign eff_period = (cmd_period < MIN_PERIOD) ? MIN_PERIOD : cmd_period;
  assign step       = (state == HIGH);
  assign busy       = (state != IDLE);
  assign cmd_ready  = (state == IDLE);

  always_comb begin
    next_state   = state;
    accept       = 1'b0;
    rise         = 1'b0;
    take_step    = 1'b0;
    finish       = 1'b0;
    finish_abort = 1'b0;
    pend_set     = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept = 1'b1;
          if (cmd_steps == '0) begin
            finish = 1'b1;
          end else if (start_blocked) begin
            finish       = 1'b1;
            finish_abort = 1'b1;
          end else begin
            next_state = SETUP;
          end
        end
      end
      SETUP: begin
        if (abort_eff) begin
          next_state   = IDLE;
          finish       = 1'b1;
          finish_abort = 1'b1;
        end else if (cnt == SETUP_LAST) begin
          next_state = HIGH;
          rise       = 1'b1;
        end
      end
      HIGH: begin
        // An abort seen mid-pulse is remembered so the pulse keeps its full width.
        if (cnt == PW_LAST) begin
          take_step = 1'b1;
          if (abort_pend || abort_eff) begin
            next_state   = IDLE;
            finish       = 1'b1;
            finish_abort = 1'b1;
          end else begin
            next_state = LOW;
          end
        end else if (abort_eff) begin
          pend_set = 1'b1;
        end
      end
      LOW: begin
        if (abort_eff) begin
          next_state   = IDLE;
          finish       = 1'b1;
          finish_abort = 1'b1;
        end else if (cnt == low_cycles - 32'd1) begin
          if (steps_left != '0) begin
            next_state = HIGH;
            rise       = 1'b1;
          end else begin
            next_state = IDLE;
            finish     = 1'b1;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      low_cycles <= '0;
      abort_pend <= 1'b0;
      dir        <= 1'b0;
      steps_left <= '0;
      position   <= '0;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      state <= next_state;
      done  <= finish;
      cnt   <= (next_state != state || state == IDLE) ? '0 : cnt + 32'd1;

      if (next_state != HIGH)
        abort_pend <= 1'b0;
      else if (pend_set)
        abort_pend <= 1'b1;

      if (accept) begin
        dir     <= cmd_dir;
        aborted <= finish_abort;
        if (cmd_steps != '0) begin
          steps_left <= cmd_steps;
          low_cycles <= eff_period - PULSE_WIDTH;
        end
      end else if (finish) begin
        aborted <= finish_abort;
      end

      if (take_step)
        steps_left <= steps_left - 1'b1;

      if (pos_clear)
        position <= '0;
      else if (rise)
        position <= dir ? position + 1'b1 : position - 1'b1;
    end
  end
endmodule

// File: tb/tb_stepper_pulse_gen.sv
// Scoreboard bench: stimulus queues expected step/done events, a monitor compares them.
module tb_stepper_pulse_gen;
  localparam int EV_RISE = 0;
  localparam int EV_FALL = 1;
  localparam int EV_DONE = 2;

  typedef struct {
    int          kind;
    int unsigned cyc;
    logic        ab;
    logic [30:0] sl;
    logic [31:0] pos;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset, cmd_valid, cmd_dir, abort, pos_clear, endstop_min, endstop_max;
  logic [30:0] cmd_steps;
  logic [31:0] cmd_period;
  logic        cmd_ready, step, dir, busy, done, aborted;
  logic [30:0] steps_left;
  logic [31:0] position;

  ev_t         exp_q[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic        prev_step = 1'b0;

  stepper_pulse_gen #(.PULSE_WIDTH(4), .DIR_SETUP(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_period(cmd_period),
    .abort(abort), .pos_clear(pos_clear), .endstop_min(endstop_min),
    .endstop_max(endstop_max), .step(step), .dir(dir), .busy(busy),
    .steps_left(steps_left), .position(position), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(int k, int unsigned c, logic ab, logic [30:0] sl, logic [31:0] p);
    ev_t e;
    e.kind = k; e.cyc = c; e.ab = ab; e.sl = sl; e.pos = p;
    exp_q.push_back(e);
  endfunction

  task automatic check_ev(input int kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d at cyc=%0d, expected no event", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.sl != steps_left || e.pos != position ||
          (kind == EV_DONE && e.ab != aborted)) begin
        errors++;
        $display("FAIL event: got kind=%0d cyc=%0d sl=%0d pos=%h ab=%b, expected kind=%0d cyc=%0d sl=%0d pos=%h ab=%b",
                 kind, cyc, steps_left, position, aborted, e.kind, e.cyc, e.sl, e.pos, e.ab);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (step && !prev_step) check_ev(EV_RISE);
      if (!step && prev_step) check_ev(EV_FALL);
      if (done) check_ev(EV_DONE);
    end
    prev_step = step;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic at(input int unsigned k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [30:0] s, input logic d, input logic [31:0] p,
                       output int unsigned a);
    @(posedge clk);
    #1;
    cmd_steps = s; cmd_dir = d; cmd_period = p; cmd_valid = 1'b1;
    a = cyc;
    chk("cmd_ready_at_accept", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned a, b;
    reset = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; abort = 1'b0; pos_clear = 1'b0;
    endstop_min = 1'b0; endstop_max = 1'b0; cmd_steps = '0; cmd_period = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_step", {31'd0, step}, 32'd0);
    chk("rst_dir", {31'd0, dir}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_aborted", {31'd0, aborted}, 32'd0);
    chk("rst_steps_left", {1'b0, steps_left}, 32'd0);
    chk("rst_position", position, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    reset = 1'b0;

    // Basic 3-step move, period 20
    issue(31'd3, 1'b1, 32'd20, a);
    push(EV_RISE, a+9, 0, 3, 1);  push(EV_FALL, a+13, 0, 2, 1);
    push(EV_RISE, a+29, 0, 2, 2); push(EV_FALL, a+33, 0, 1, 2);
    push(EV_RISE, a+49, 0, 1, 3); push(EV_FALL, a+53, 0, 0, 3);
    push(EV_DONE, a+69, 0, 0, 3);
    at(a+10);
    chk("busy_moving", {31'd0, busy}, 32'd1);
    chk("ready_moving", {31'd0, cmd_ready}, 32'd0);
    chk("dir_moving", {31'd0, dir}, 32'd1);
    at(a+72);
    chk("busy_after", {31'd0, busy}, 32'd0);

    // Zero-step command
    issue(31'd0, 1'b0, 32'd20, a);
    push(EV_DONE, a+1, 0, 0, 3);
    chk("zero_ready", {31'd0, cmd_ready}, 32'd1);
    at(a+4);

    // Clamped period, dir=0, commands offered while busy are ignored
    issue(31'd2, 1'b0, 32'd5, a);
    push(EV_RISE, a+9, 0, 2, 2);  push(EV_FALL, a+13, 0, 1, 2);
    push(EV_RISE, a+17, 0, 1, 1); push(EV_FALL, a+21, 0, 0, 1);
    push(EV_DONE, a+25, 0, 0, 1);
    cmd_valid = 1'b1; cmd_steps = 31'd99; cmd_dir = 1'b1;
    at(a+2);
    chk("ready_busy", {31'd0, cmd_ready}, 32'd0);
    at(a+5);
    cmd_valid = 1'b0;
    at(a+10);
    chk("dir_stable", {31'd0, dir}, 32'd0);
    at(a+28);

    // Abort on 2nd cycle of 3rd pulse
    issue(31'd10, 1'b1, 32'd20, a);
    push(EV_RISE, a+9, 0, 10, 2); push(EV_FALL, a+13, 0, 9, 2);
    push(EV_RISE, a+29, 0, 9, 3); push(EV_FALL, a+33, 0, 8, 3);
    push(EV_RISE, a+49, 0, 8, 4); push(EV_FALL, a+53, 0, 7, 4);
    push(EV_DONE, a+53, 1, 7, 4);
    at(a+50); abort = 1'b1;
    at(a+51); abort = 1'b0;
    at(a+56);
    chk("busy_after_abort", {31'd0, busy}, 32'd0);

    // Abort with cmd_valid in IDLE is ignored; abort in SETUP ends the move
    abort = 1'b1;
    issue(31'd5, 1'b1, 32'd20, a);
    abort = 1'b0;
    push(EV_DONE, a+4, 1, 5, 4);
    at(a+2);
    chk("accepted_with_abort", {31'd0, busy}, 32'd1);
    at(a+3); abort = 1'b1;
    at(a+4); abort = 1'b0;
    at(a+7);

    // pos_clear in idle, then wrap below zero and back
    pos_clear = 1'b1;
    at(a+8); pos_clear = 1'b0;
    chk("pos_clear_idle", position, 32'd0);
    issue(31'd1, 1'b0, 32'd8, a);
    push(EV_RISE, a+9, 0, 1, 32'hFFFF_FFFF); push(EV_FALL, a+13, 0, 0, 32'hFFFF_FFFF);
    push(EV_DONE, a+17, 0, 0, 32'hFFFF_FFFF);
    at(a+19);
    issue(31'd2, 1'b1, 32'd8, a);
    push(EV_RISE, a+9, 0, 2, 0);  push(EV_FALL, a+13, 0, 1, 0);
    push(EV_RISE, a+17, 0, 1, 0); push(EV_FALL, a+21, 0, 0, 0);
    push(EV_DONE, a+25, 0, 0, 0);
    at(a+16); pos_clear = 1'b1;
    at(a+17); pos_clear = 1'b0;
    at(a+28);

    // Endstop in travel direction raised during LOW of the 2nd step
    issue(31'd4, 1'b1, 32'd20, a);
    push(EV_RISE, a+9, 0, 4, 1);  push(EV_FALL, a+13, 0, 3, 1);
    push(EV_RISE, a+29, 0, 3, 2); push(EV_FALL, a+33, 0, 2, 2);
`ifdef STEPPER_ENDSTOP_ABORT_EN
    push(EV_DONE, a+37, 1, 2, 2);
    at(a+34); endstop_max = 1'b1;
    at(a+40);
    issue(31'd3, 1'b1, 32'd20, b);
    push(EV_DONE, b+1, 1, 3, 2);
    at(b+3); endstop_max = 1'b0;
    at(b+6);
    b = 3;
`else
    push(EV_RISE, a+49, 0, 2, 3); push(EV_FALL, a+53, 0, 1, 3);
    push(EV_RISE, a+69, 0, 1, 4); push(EV_FALL, a+73, 0, 0, 4);
    push(EV_DONE, a+89, 0, 0, 4);
    at(a+34); endstop_max = 1'b1;
    at(a+92); endstop_max = 1'b0;
    b = 5;
`endif

    // Reset mid-pulse: step drops next cycle, no done
    issue(31'd5, 1'b1, 32'd20, a);
    push(EV_RISE, a+9, 0, 5, b);
    push(EV_FALL, a+11, 0, 0, 0);
    at(a+10); reset = 1'b1;
    at(a+11); reset = 1'b0;
    chk("mid_rst_step", {31'd0, step}, 32'd0);
    chk("mid_rst_position", position, 32'd0);
    chk("mid_rst_aborted", {31'd0, aborted}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    at(a+40);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stepper_pulse_gen.md
STEPPER_PULSE_GEN -- requirements
Module: stepper_pulse_gen

Interface
REQ-001 SHALL have parameter PULSE_WIDTH, default 4, STEP high time in clocks (>=1).
REQ-002 SHALL have parameter DIR_SETUP, default 8, DIR-to-first-STEP setup in clocks (>=1).
REQ-003 clk  input  1  single clock, all logic rising-edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 cmd_valid  input  1  command offered; cmd_ready  output  1  block idle and accepting.
REQ-006 cmd_steps  input  31  step count; cmd_dir  input  1  1=positive/max, 0=negative/min.
REQ-007 cmd_period  input  32  clocks per step (rising edge to rising edge).
REQ-008 abort  input  1  stop after current pulse; pos_clear  input  1  zero position.
REQ-009 endstop_min, endstop_max  input  1 each  asynchronous, active-high.
REQ-010 step  output  1; dir  output  1; busy  output  1.
REQ-011 steps_left  output  31  remaining steps; position  output  32  signed step position.
REQ-012 done  output  1  one-cycle completion pulse; aborted  output  1  last move was cut short.

Function
REQ-013 Handshake SHALL complete in cycle A where cmd_valid&cmd_ready; cmd_ready SHALL equal (state==IDLE).
REQ-014 FSM SHALL have states IDLE, SETUP, HIGH, LOW.
REQ-015 IDLE+accept, cmd_steps!=0: latch steps/period, dir<=cmd_dir, aborted<=0, go SETUP; first step rise SHALL be cycle A+DIR_SETUP+1.
REQ-016 IDLE+accept, cmd_steps==0: stay IDLE, done=1 in A+1, no step, aborted<=0.
REQ-017 HIGH: step=1 for PULSE_WIDTH cycles, then LOW; steps_left SHALL decrement on the HIGH->LOW transition.
REQ-018 LOW: step=0 for eff_period-PULSE_WIDTH cycles; then HIGH if steps_left!=0, else IDLE with done=1 for one cycle.
REQ-019 eff_period SHALL be max(cmd_period, 2*PULSE_WIDTH); 32-bit unsigned compare, no overflow.
REQ-020 position SHALL change by +1 (dir=1) or -1 (dir=0) in the cycle step rises; two's-complement wrap.
REQ-021 pos_clear SHALL set position to 0 next cycle, overriding a same-cycle increment.
REQ-022 abort in SETUP or LOW SHALL go IDLE next cycle; in HIGH the pulse SHALL finish full width first; then done=1, aborted=1, steps_left holds untaken count.
REQ-023 abort in IDLE SHALL be ignored; abort with cmd_valid in IDLE: command accepted.
REQ-024 cmd_valid while busy SHALL be ignored; dir SHALL be stable from SETUP until IDLE.
REQ-025 busy SHALL equal (state!=IDLE).
REQ-026 Endstops SHALL pass a 2-flop synchronizer before use.

Reset
REQ-027 reset SHALL force IDLE, step=0, dir=0, done=0, aborted=0, steps_left=0, position=0, synchronizer flops=0.
REQ-028 reset mid-move SHALL drop step in the next cycle with no done pulse.

Configuration
REQ-029 With STEPPER_ENDSTOP_ABORT_EN defined: synchronized endstop_min (dir=0) or endstop_max (dir=1) SHALL act as abort (REQ-022); accepting a move into an active endstop SHALL give done=1, aborted=1 at A+1, no step.
REQ-030 Without STEPPER_ENDSTOP_ABORT_EN: endstops SHALL not affect motion; synchronizer still present.

Structure
REQ-031 Package stepper_pkg SHALL hold the state enum and STEP_CNT_W=31, POS_W=32, PERIOD_W=32.
REQ-032 Sub-module stepper_sync2 SHALL implement the 2-flop synchronizer, instanced twice.

Verification (PULSE_WIDTH=4, DIR_SETUP=8)
REQ-033 steps=3, period=20, dir=1 accepted at A -> rises at A+9, A+29, A+49, each 4 cycles high; done at A+69; position +3; steps_left 0.
REQ-034 steps=0 -> done at A+1, step never high, cmd_ready stays 1.
REQ-035 steps=2, period=5 -> rise spacing 8 cycles (clamped).
REQ-036 steps=10, abort on 2nd cycle of 3rd HIGH -> pulse stays high 4 cycles, done next, aborted=1, steps_left=7, position +3.
REQ-037 position=0x7FFFFFFF, one step dir=1 -> 0x80000000; pos_clear on a rise cycle -> position 0.
REQ-038 macro on, endstop_max rises mid-move dir=1 -> no further rises after synchronizer latency, aborted=1; macro off -> move completes.
